serial_frame_tx: RTL and testbench
==================================

Name: serial_frame_tx

Overview:
- Parallel-to-serial framed transmitter; produces the single-bit serial stream that a flop-based sampler downstream receives on its `d` input.
- Accepts a WIDTH-bit word over a valid/ready handshake.
- Emits each frame as: start bit (0), WIDTH data bits LSB-first, stop bit (1). Every bit is held for DIV clock cycles.
- Used as the stimulus/driver end of the serial-link exercises; the line idles high.

Parameters:
- WIDTH, 8, data bits per frame (legal range 1..32).
- DIV, 4, clock cycles per serial bit (legal range 1..256).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- clear  input  1  asynchronous active-low reset; forces idle state immediately.
- data_in  input  WIDTH  word to transmit; sampled only on the accept edge.
- valid  input  1  upstream has a word on data_in.
- ready  output  1  block can accept a word this cycle.
- tx  output  1  serial line; registered; idles 1.
- busy  output  1  frame in progress (any state other than IDLE).

Behaviour:
- Reset values (clear=0, asynchronous): state=IDLE, tx=1, ready=1, busy=0, shift register=0, bit counter=0, divider counter=0.
- States and meaning:
  - IDLE: tx=1, ready=1, busy=0.
  - START: tx=0.
  - DATA: tx = current LSB of the shift register.
  - STOP: tx=1.
- ready=1 only in IDLE. busy=1 in START, DATA and STOP.
- Accept: a rising edge with state=IDLE and valid=1.
  - data_in is latched into the shift register.
  - State goes to START; tx goes to 0 at that same edge (registered, zero-cycle latency from the accept edge).
  - ready and busy update at the same edge.
- Divider:
  - The counter runs 0..DIV-1 in every non-IDLE state.
  - The state advances, or the next bit is presented, when the counter = DIV-1; the counter then wraps to 0.
  - With DIV=1 the counter is constant 0 and every cycle is a bit boundary.
- START→DATA after DIV cycles. tx = shift[0] from that edge.
- DATA bit handling:
  - At each bit boundary, shift right by 1 and increment the bit counter.
  - After WIDTH bits, go to STOP with tx=1.
  - Bit counter width: clog2(WIDTH+1).
- STOP→IDLE after DIV cycles; ready=1 from that edge.
- Frame length: exactly (WIDTH+2)*DIV cycles from the accept edge to the return to IDLE.
- Back-to-back frames: if valid is held high, the next accept happens on the first IDLE cycle. The line therefore stays high for DIV+1 cycles between frames (stop bit plus one idle cycle). No frame overlap.
- valid is ignored while busy=1. data_in changes during a frame do not affect tx.
- Reset mid-frame: the frame is abandoned and tx returns to 1 asynchronously. After clear is released, the block waits in IDLE; there is no resumption.
- valid=1 coincident with clear release: no accept until the first rising edge with clear=1.
- No glitches on tx: it is driven only from a register.

Test Plan:
- Reset and idle: assert clear=0 mid-simulation, then release; hold valid=0 for 20 cycles → tx=1, ready=1, busy=0 throughout.
- Single frame (WIDTH=8, DIV=4), data_in=8'hA5, one-cycle valid pulse:
  - tx per 4-cycle bit slot: 0,1,0,1,0,0,1,0,1,1.
  - busy high for exactly 40 cycles; ready low for the same 40 cycles.
- Back-to-back: valid held high with 8'h00 then 8'hFF:
  - Frame 1 data bits all 0; frame 2 data bits all 1.
  - Exactly 5 cycles of tx=1 between frame-1's last data bit and frame-2's start bit.
- Input stability: change data_in to 8'h3C and pulse valid during a frame of 8'h81 → transmitted bits are those of 8'h81; the second request is not accepted until ready=1.
- Reset mid-frame: pull clear low during the 3rd data bit → tx=1 and busy=0 immediately (before the next edge). After release, a new 8'h5A frame transmits correctly.
- DIV=1, WIDTH=4, data_in=4'b0110 → tx per cycle: 0,0,1,1,0,1; frame length 6 cycles.

Source files
------------

// File: rtl/serial_frame_tx_if.sv
// Word handshake plus serial line of the framed transmitter.
// master = upstream word source, slave = transmitter.
interface serial_frame_tx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             valid;
  logic             ready;
  logic             tx;
  logic             busy;

  modport master (
    output data_in,
    output valid,
    input  ready,
    input  tx,
    input  busy
  );

  modport slave (
    input  data_in,
    input  valid,
    output ready,
    output tx,
    output busy
  );
endinterface

// File: rtl/serial_frame_tx.sv
// Framed parallel-to-serial transmitter: start(0), WIDTH bits LSB-first, stop(1), DIV clocks per bit.
// tx goes low on the accept edge; ready stays low for the whole (WIDTH+2)*DIV-cycle frame.
module serial_frame_tx #(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic                clk,
  input  logic                clear,
  serial_frame_tx_if.slave    bus
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state;
  logic [WIDTH-1:0] shift;
  logic [BW-1:0]    bit_cnt;
  logic [DW-1:0]    div_cnt;
  logic             tx_q;
  logic             ready_q;
  logic             busy_q;

  logic             bit_end;
  logic [WIDTH-1:0] shift_nxt;

  // With DIV=1 the counter never leaves 0, so every cycle is a bit boundary.
  assign bit_end   = (div_cnt == DIV_LAST);
  assign shift_nxt = shift >> 1;

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state   <= IDLE;
      shift   <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.valid) begin
            shift   <= bus.data_in;
            bit_cnt <= '0;
            div_cnt <= '0;
            state   <= START;
            tx_q    <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            div_cnt <= '0;
            state   <= DATA;
            tx_q    <= shift[0];
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            div_cnt <= '0;
            shift   <= shift_nxt;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == BIT_LAST) begin
              state <= STOP;
              tx_q  <= 1'b1;
            end else begin
              tx_q  <= shift_nxt[0];
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            div_cnt <= '0;
            state   <= IDLE;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.tx    = tx_q;
  assign bus.ready = ready_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: an 8-bit/DIV=4 instance under directed and random traffic against a
// frame-queue model, and a 4-bit/DIV=1 instance driven from a per-cycle vector table.
module tb_serial_frame_tx;

  logic clk = 1'b0;
  logic clear = 1'b0;
  always #5 clk = ~clk;

  serial_frame_tx_if #(.WIDTH(8)) a_if ();
  serial_frame_tx_if #(.WIDTH(4)) b_if ();

  serial_frame_tx #(.WIDTH(8), .DIV(4)) dut_a (.clk(clk), .clear(clear), .bus(a_if.slave));
  serial_frame_tx #(.WIDTH(4), .DIV(1)) dut_b (.clk(clk), .clear(clear), .bus(b_if.slave));

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an accepted word becomes a queue of per-cycle line levels.
  bit   q[$];
  logic m_tx   = 1'b1;
  logic m_busy = 1'b0;
  bit   chk_en = 1'b0;

  always @(posedge clk or negedge clear) begin
    bit b;
    if (!clear) begin
      q.delete();
      m_tx   = 1'b1;
      m_busy = 1'b0;
    end else begin
      if (!m_busy && a_if.valid === 1'b1) begin
        for (int s = 0; s < 10; s++) begin
          b = (s == 0) ? 1'b0 : (s == 9) ? 1'b1 : a_if.data_in[s-1];
          repeat (4) q.push_back(b);
        end
      end
      if (q.size() > 0) begin
        m_tx   = q.pop_front();
        m_busy = 1'b1;
      end else begin
        m_tx   = 1'b1;
        m_busy = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en)
      check("live_a", {29'd0, a_if.tx, a_if.busy, a_if.ready}, {29'd0, m_tx, m_busy, ~m_busy});
  end

  logic cap_tx    [0:99];
  logic cap_busy  [0:99];
  logic cap_ready [0:99];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [7:0] d);
    a_if.valid   = 1'b1;
    a_if.data_in = d;
    tick();
    a_if.valid   = 1'b0;
  endtask

  task automatic capture(input int n, input int pulse_at);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cap_tx[i]    = a_if.tx;
      cap_busy[i]  = a_if.busy;
      cap_ready[i] = a_if.ready;
      if (i == pulse_at) begin
        check("ready_low_during_frame", a_if.ready, 1'b0);
        a_if.valid   = 1'b1;
        a_if.data_in = 8'h3C;
      end
      if (i == pulse_at + 2) a_if.valid = 1'b0;
    end
  endtask

  function automatic logic [9:0] slots_of(input logic [7:0] d);
    return {1'b1, d, 1'b0};
  endfunction

  task automatic check_slots(input string name, input int base, input logic [9:0] exp);
    for (int k = 0; k < 10; k++)
      check($sformatf("%s_slot%0d", name, k),
            {cap_tx[base+4*k], cap_tx[base+4*k+1], cap_tx[base+4*k+2], cap_tx[base+4*k+3]},
            {4{exp[k]}});
  endtask

  typedef struct {
    logic       v;
    logic [3:0] d;
    logic       tx;
    logic       busy;
    logic       ready;
  } vec_t;

  vec_t tbl [21];

  initial begin
    #500000;
    n_err++;
    $display("FAIL watchdog expired at %0t", $time);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $fatal(1, "timeout");
  end

  initial begin
    int cnt_b;
    int cnt_r;
    int idx2;
    int ones;
    int hold;

    tbl[0]  = '{1'b1, 4'b0110, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 4'b0000, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 4'b0000, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 4'b1001, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 4'b1111, 1'b1, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 4'b1111, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 4'b1111, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 4'b1111, 1'b1, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 4'b1111, 1'b1, 1'b1, 1'b0};
    tbl[13] = '{1'b1, 4'b0001, 1'b1, 1'b0, 1'b1};
    tbl[14] = '{1'b1, 4'b0001, 1'b0, 1'b1, 1'b0};
    tbl[15] = '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b0};
    tbl[16] = '{1'b0, 4'b0000, 1'b0, 1'b1, 1'b0};
    tbl[17] = '{1'b0, 4'b0000, 1'b0, 1'b1, 1'b0};
    tbl[18] = '{1'b0, 4'b0000, 1'b0, 1'b1, 1'b0};
    tbl[19] = '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b0};
    tbl[20] = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b1};

    a_if.valid = 1'b0; a_if.data_in = '0;
    b_if.valid = 1'b0; b_if.data_in = '0;

    // Reset, then 20 idle cycles with valid low.
    repeat (3) tick();
    check("reset_tx",    a_if.tx,    1'b1);
    check("reset_ready", a_if.ready, 1'b1);
    check("reset_busy",  a_if.busy,  1'b0);
    clear = 1'b1;
    chk_en = 1'b1;
    repeat (20) tick();
    check("idle_after_20", {a_if.tx, a_if.ready, a_if.busy}, 3'b110);

    // Single 8'hA5 frame with a one-cycle valid pulse.
    send_a(8'hA5);
    capture(44, -1);
    check_slots("a5", 0, 10'b1101001010);
    cnt_b = 0; cnt_r = 0;
    for (int i = 0; i < 44; i++) begin
      if (cap_busy[i])   cnt_b++;
      if (!cap_ready[i]) cnt_r++;
    end
    check("a5_busy_cycles",  cnt_b, 40);
    check("a5_ready_low",    cnt_r, 40);

    // Back-to-back: valid held high through 8'h00 then 8'hFF.
    tick();
    a_if.valid = 1'b1; a_if.data_in = 8'h00;
    tick();
    a_if.data_in = 8'hFF;
    idx2 = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      cap_tx[i]   = a_if.tx;
      cap_busy[i] = a_if.busy;
      if (i > 0 && idx2 < 0 && !cap_busy[i-1] && cap_busy[i]) begin
        idx2 = i;
        a_if.valid = 1'b0;
      end
    end
    a_if.valid = 1'b0;
    check("b2b_second_start", idx2, 41);
    check_slots("b2b_f1", 0, slots_of(8'h00));
    ones = 0;
    for (int i = 36; i < 100; i++) begin
      if (!cap_tx[i]) break;
      ones++;
    end
    check("b2b_gap_ones", ones, 5);
    if (idx2 >= 0 && idx2 <= 60) check_slots("b2b_f2", idx2, slots_of(8'hFF));

    // Request with new data during a frame is neither latched nor accepted.
    tick();
    send_a(8'h81);
    capture(48, 10);
    check_slots("stab_81", 0, slots_of(8'h81));
    check("stab_no_accept", {cap_busy[41], cap_busy[44], cap_busy[47]}, 3'b000);

    // Clear during the third data bit of an all-zero frame.
    tick();
    send_a(8'h00);
    repeat (13) tick();
    check("pre_clear_tx", a_if.tx, 1'b0);
    clear = 1'b0;
    #1;
    check("clear_async_tx",   a_if.tx,    1'b1);
    check("clear_async_busy", a_if.busy,  1'b0);
    check("clear_async_rdy",  a_if.ready, 1'b1);
    repeat (2) tick();
    check("clear_held_idle", {a_if.tx, a_if.busy}, 2'b10);
    clear = 1'b1;
    send_a(8'h5A);
    capture(44, -1);
    check_slots("after_clear_5a", 0, slots_of(8'h5A));

    // Random traffic with occasional clears, checked by the model.
    for (int f = 0; f < 40; f++) begin
      repeat ($urandom_range(0, 3)) tick();
      a_if.valid = 1'b1;
      a_if.data_in = 8'($urandom);
      hold = $urandom_range(1, 60);
      for (int c = 0; c < hold; c++) begin
        tick();
        a_if.data_in = 8'($urandom);
        if ($urandom_range(0, 99) == 0) begin
          clear = 1'b0;
          tick();
          clear = 1'b1;
        end
      end
      a_if.valid = 1'b0;
    end
    repeat (50) tick();

    // DIV=1, WIDTH=4 instance from the vector table.
    for (int i = 0; i < 21; i++) begin
      b_if.valid   = tbl[i].v;
      b_if.data_in = tbl[i].d;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("tbl_row%0d", i), {b_if.tx, b_if.busy, b_if.ready},
            {tbl[i].tx, tbl[i].busy, tbl[i].ready});
    end
    b_if.valid = 1'b0;

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
